piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the bit-counter width, equal to clog2(WIDTH).
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n; no other clock or reset SHALL exist.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_data, input, WIDTH bits: parallel word to serialize.
REQ-007 Port in_valid, input, 1 bit: in_data is valid.
REQ-008 Port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 Port msb_first, input, 1 bit: bit order select (1 = MSB first); sampled only at word accept.
REQ-010 Port shift_en, input, 1 bit: downstream consumes the current serial bit this cycle.
REQ-011 Port ser_out, output, 1 bit: current serial bit.
REQ-012 Port ser_valid, output, 1 bit: ser_out is valid.
REQ-013 Port frame_last, output, 1 bit: ser_out is the final bit of the word.
REQ-014 Port busy, output, 1 bit: a word is held (state SHIFT).

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-016 IDLE: in_ready=1, ser_valid=0; a word is accepted on in_valid&in_ready, and the FSM goes to SHIFT.
REQ-017 On accept, the block SHALL load in_data into the shift register, latch msb_first, and set count=WIDTH-1.
REQ-018 Latency: a word accepted at edge N SHALL present its first bit with ser_valid=1 in the cycle after edge N.
REQ-019 In SHIFT, ser_valid=1 and ser_out=sreg[WIDTH-1] if msb_first was latched as 1, else sreg[0].
REQ-020 The bit advances only on an edge with ser_valid&shift_en: sreg shifts toward the output end, zero-filling, and count decrements.
REQ-021 With shift_en=0, the block SHALL hold ser_out, count and sreg unchanged for any number of cycles.
REQ-022 frame_last SHALL equal ser_valid & (count==0).
REQ-023 In SHIFT, in_ready SHALL equal (count==0)&shift_en, which permits back-to-back words with no gap cycle.
REQ-024 If the last bit is consumed and a new word is accepted on the same edge, the block SHALL reload and stay in SHIFT; otherwise it SHALL return to IDLE.
REQ-025 in_valid while in_ready=0 SHALL be ignored, with no state change; the upstream holds in_data.
REQ-026 busy SHALL equal (state==SHIFT).
REQ-027 in_data and msb_first SHALL NOT affect an in-flight word.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, sreg=0, count=0, ser_out=0, ser_valid=0, frame_last=0 and busy=0, with in_ready=1 after release.
REQ-029 Reset asserted mid-frame SHALL discard the word; no partial bits SHALL appear after release.
REQ-030 All flops SHALL use the asynchronous active-low reset; no output SHALL be X after reset.

Structure
REQ-031 State encodings (ST_IDLE, ST_SHIFT) and the WIDTH/CNT_W defaults SHALL live in shared package serial_pkg.
REQ-032 The down-counter SHALL be the sub-module bit_counter (load, decrement enable, zero flag).
REQ-033 in_ready, ser_out, ser_valid and frame_last SHALL be combinational decodes of registered state plus shift_en; there SHALL be no combinational path from in_data to any output.

Verification
REQ-034 Load 0x0F with msb_first=1 and shift_en=1 -> ser_out 0,0,0,0,1,1,1,1 over 8 cycles, frame_last only on the 8th, then IDLE.
REQ-035 Load 0x0F with msb_first=0 -> ser_out 1,1,1,1,0,0,0,0.
REQ-036 Load 0xA5 (MSB first) with shift_en low for 3 cycles after bit 2 -> bit 2 (1) held 4 cycles, then the remaining 0,0,1,0,1.
REQ-037 Offer 0x81 then 0x7E with in_valid held high -> 16 contiguous valid bits 1000000101111110, second accept on the frame_last edge.
REQ-038 Load 0xFF, then pulse rst_n low after 3 bits -> outputs 0 immediately, busy=0, and no further ser_valid until a new accept.
REQ-039 Present 0x3C while busy mid-frame -> not accepted and the in-flight word is unchanged; 0x3C is accepted only on the final-bit edge.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the parallel-in/serial-out datapath:
// FSM encodings and default geometry.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;

endpackage

// File: rtl/bit_counter.sv
// Down-counter that tracks the remaining bits of the word being serialized.
// Load wins over decrement; the counter saturates at zero.
module bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with selectable bit order, downstream
// back-pressure and zero-gap back-to-back word acceptance.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | no word held; ready for a new word
//   ST_SHIFT | word held; presenting one bit per shift_en
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last,
  output logic             busy
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sreg;
  logic             msb_lat;
  logic             zero;
  logic             accept;
  logic             advance;

  // Every output is a decode of registered state plus shift_en, so in_data
  // never reaches an output combinationally.
  assign busy       = (state == ST_SHIFT);
  assign ser_valid  = busy;
  assign ser_out    = busy & (msb_lat ? sreg[WIDTH-1] : sreg[0]);
  assign frame_last = ser_valid & zero;
  assign in_ready   = ~busy | (zero & shift_en);
  assign accept     = in_valid & in_ready;
  assign advance    = ser_valid & shift_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (advance && zero) state_nx = accept ? ST_SHIFT : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      msb_lat <= 1'b0;
    end else if (accept) begin
      sreg    <= in_data;
      msb_lat <= msb_first;
    end else if (advance) begin
      sreg <= msb_lat ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    end
  end

  bit_counter #(
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .load_val(CNT_W'(WIDTH - 1)),
    .dec     (advance),
    .zero    (zero)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus random traffic, all
// checked against a queue-of-pending-bits reference model.
module tb_piso_serializer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             msb_first = 1'b0;
  logic             shift_en = 1'b0;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_last;
  logic             busy;

  int          nchk = 0;
  int          nfail = 0;
  bit          mq[$];
  logic [31:0] cap;
  int          ncap;

  piso_serializer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msb_first (msb_first),
    .shift_en  (shift_en),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .frame_last(frame_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then let the
  // edge happen and update the model from the pre-edge handshake.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic m, input logic s);
    bit exp_valid, exp_out, exp_last, exp_ready, acc;
    @(negedge clk);
    in_valid = v; in_data = d; msb_first = m; shift_en = s;
    #1;
    exp_valid = (mq.size() != 0);
    exp_out   = exp_valid ? mq[0] : 1'b0;
    exp_last  = (mq.size() == 1);
    exp_ready = (mq.size() == 0) || ((mq.size() == 1) && s);
    check_eq("ser_valid", 32'(ser_valid), 32'(exp_valid));
    check_eq("ser_out", 32'(ser_out), 32'(exp_out));
    check_eq("frame_last", 32'(frame_last), 32'(exp_last));
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("busy", 32'(busy), 32'(exp_valid));
    if (exp_valid && s) begin
      cap = (cap << 1) | 32'(ser_out);
      ncap++;
    end
    acc = v && exp_ready;
    @(posedge clk);
    if (exp_valid && s) void'(mq.pop_front());
    if (acc) begin
      for (int i = 0; i < WIDTH; i++) mq.push_back(m ? d[WIDTH-1-i] : d[i]);
    end
  endtask

  task automatic clear_cap();
    cap = '0;
    ncap = 0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ser_valid", 32'(ser_valid), 32'd0);
    check_eq("rst_ser_out", 32'(ser_out), 32'd0);
    check_eq("rst_frame_last", 32'(frame_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);

    // 0x0F MSB first
    clear_cap();
    cycle(1'b1, 8'h0F, 1'b1, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("msb_0f_bits", cap, 32'h0F);
    check_eq("msb_0f_ncap", 32'(ncap), 32'd8);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // 0x0F LSB first: 1,1,1,1,0,0,0,0
    clear_cap();
    cycle(1'b1, 8'h0F, 1'b0, 1'b1);
    repeat (8) cycle(1'b0, 8'hFF, 1'b1, 1'b1);
    check_eq("lsb_0f_bits", cap, 32'hF0);

    // 0xA5 with a 3-cycle stall on the third bit
    clear_cap();
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("stall_hold", 32'(ser_out), 32'd1);
    end
    repeat (6) cycle(1'b0, '0, 1'b0, 1'b1);
    check_eq("a5_bits", cap, 32'hA5);

    // 0x81 then 0x7E back-to-back with in_valid held
    clear_cap();
    cycle(1'b1, 8'h81, 1'b1, 1'b1);
    repeat (8) cycle(1'b1, 8'h7E, 1'b1, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("b2b_bits", cap, 32'h817E);
    check_eq("b2b_ncap", 32'(ncap), 32'd16);

    // 0x3C offered while busy is only taken on the final-bit edge
    clear_cap();
    cycle(1'b1, 8'hC3, 1'b1, 1'b1);
    repeat (8) cycle(1'b1, 8'h3C, 1'b0, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("busy_offer_bits", cap, 32'hC33C);

    // reset mid-frame after 3 bits of 0xFF
    cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; shift_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ser_valid", 32'(ser_valid), 32'd0);
    check_eq("mid_rst_ser_out", 32'(ser_out), 32'd0);
    check_eq("mid_rst_frame_last", 32'(frame_last), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle(1'b0, 8'hFF, 1'b1, 1'b1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end
    repeat (12) cycle(1'b0, '0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", nchk);
    $fatal(1, "timeout");
  end

endmodule
